// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared constants and types for the RV32I/RV64I decode stage.
//   - ALU operation codes (must match the execute-stage ALU)
//   - major opcode constants for the nine supported instruction classes
//   - ctrl_t: the control half of a decoded instruction bundle
package decode_stage_pkg;

  localparam int ALU_OP_BITS = 4;

  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    pc_src;
    logic    branch_sel;
    logic    jump_sel;
    logic    mr_sel;
    logic    mw_sel;
    logic    mtr_sel;
    logic    rw_sel;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_comb.sv
// decode_stage_comb
//   Pure combinational RV32I/RV64I decoder: raw instruction in, register
//   indices, sign-extended immediate and control selects out. Also reports
//   which source registers the instruction actually reads, for hazard checks.
// Ports:
//   instr            raw 32-bit instruction
//   rs1, rs2, rd     register indices (rs1 forced to x0 for LUI)
//   funct3           instr[14:12] passthrough
//   imm              XLEN-wide immediate
//   ctrl             alu_op and datapath selects, plus illegal flag
//   uses_rs1/2       instruction reads rs1 / rs2
module decode_stage_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output ctrl_t           ctrl,
  output logic            uses_rs1,
  output logic            uses_rs2
);

  // RV64 shifts take a 6-bit shamt; RV32 only uses instr[24:20].
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Signed size casts sign-extend each format from its top bit.
  assign imm_i  = XLEN'(signed'(instr[31:20]));
  assign imm_s  = XLEN'(signed'({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'(signed'({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_sh = XLEN'(instr[20 +: SHAMT_W]);

  always_comb begin
    rs1      = instr[19:15];
    imm      = '0;
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;

    case (instr[6:0])
      OPC_OP: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        ctrl.rw_sel = 1'b1;
        case ({funct7[5], funct3})
          4'b0000: ctrl.alu_op = ALU_ADD;
          4'b1000: ctrl.alu_op = ALU_SUB;
          4'b0001: ctrl.alu_op = ALU_SLL;
          4'b0010: ctrl.alu_op = ALU_SLT;
          4'b0011: ctrl.alu_op = ALU_SLTU;
          4'b0100: ctrl.alu_op = ALU_XOR;
          4'b0101: ctrl.alu_op = ALU_SRL;
          4'b1101: ctrl.alu_op = ALU_SRA;
          4'b0110: ctrl.alu_op = ALU_OR;
          4'b0111: ctrl.alu_op = ALU_AND;
          default: ctrl.alu_op = ALU_ADD;
        endcase
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) ctrl.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        uses_rs1     = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.rw_sel  = 1'b1;
        imm          = imm_i;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b001: begin
            ctrl.alu_op = ALU_SLL;
            imm         = imm_sh;
          end
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b101: begin
            ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            imm         = imm_sh;
          end
          3'b110: ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1     = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.mr_sel  = 1'b1;
        ctrl.mtr_sel = 1'b1;
        ctrl.rw_sel  = 1'b1;
        imm          = imm_i;
      end
      OPC_STORE: begin
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.mw_sel  = 1'b1;
        imm          = imm_s;
      end
      OPC_BRANCH: begin
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.branch_sel = 1'b1;
        imm             = imm_b;
      end
      OPC_LUI: begin
        rs1          = 5'd0;
        ctrl.alu_src = 1'b1;
        ctrl.rw_sel  = 1'b1;
        imm          = imm_u;
      end
      OPC_AUIPC: begin
        ctrl.alu_src = 1'b1;
        ctrl.pc_src  = 1'b1;
        ctrl.rw_sel  = 1'b1;
        imm          = imm_u;
      end
      OPC_JAL: begin
        ctrl.jump_sel = 1'b1;
        ctrl.pc_src   = 1'b1;
        ctrl.rw_sel   = 1'b1;
        imm           = imm_j;
      end
      OPC_JALR: begin
        uses_rs1      = 1'b1;
        ctrl.jump_sel = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.rw_sel   = 1'b1;
        imm           = imm_i;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // An illegal instruction must never change architectural state.
    if (ctrl.illegal) begin
      ctrl.rw_sel     = 1'b0;
      ctrl.mw_sel     = 1'b0;
      ctrl.mr_sel     = 1'b0;
      ctrl.branch_sel = 1'b0;
      ctrl.jump_sel   = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered decode stage between fetch and execute. Decodes the incoming
//   instruction and holds the result in an output pipeline register.
//   Inserts one bubble on a load-use hazard and supports a synchronous flush.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  drop the held bundle and refuse input this cycle
//   in_valid/in_ready      instr + in_pc handshake from fetch
//   out_valid/out_ready    decoded bundle handshake to execute
//   out_pc, rs1, rs2, rd, imm, alu_op, funct3, *_sel, illegal   bundle
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                pc_src,
  output logic                branch_sel,
  output logic                jump_sel,
  output logic                mr_sel,
  output logic                mw_sel,
  output logic                mtr_sel,
  output logic                rw_sel,
  output logic [2:0]          funct3,
  output logic                illegal
);

  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [2:0]      dec_funct3;
  logic [XLEN-1:0] dec_imm;
  ctrl_t           dec_ctrl;
  logic            dec_uses_rs1, dec_uses_rs2;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      funct3_q, funct3_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic hazard, in_fire, out_fire;

  decode_stage_comb #(.XLEN(XLEN)) u_comb (
    .instr    (instr),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .funct3   (dec_funct3),
    .imm      (dec_imm),
    .ctrl     (dec_ctrl),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  // A held load whose destination the incoming instruction reads must leave
  // before that instruction is accepted; this yields exactly one bubble.
  assign hazard = out_valid_q & ctrl_q.mr_sel & (rd_q != 5'd0) &
                  ((dec_uses_rs1 & (dec_rs1 == rd_q)) |
                   (dec_uses_rs2 & (dec_rs2 == rd_q)));

  assign in_ready = ~flush & ~hazard & (~out_valid_q | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    funct3_d    = funct3_q;
    ctrl_d      = ctrl_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      pc_d        = in_pc;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      rd_d        = dec_rd;
      imm_d       = dec_imm;
      funct3_d    = dec_funct3;
      ctrl_d      = dec_ctrl;
    end else if (out_fire || flush) begin
      // Data fields keep their stale values; only valid drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      funct3_q    <= '0;
      ctrl_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      funct3_q    <= funct3_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = pc_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign imm        = imm_q;
  assign funct3     = funct3_q;
  assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);
  assign alu_src    = ctrl_q.alu_src;
  assign pc_src     = ctrl_q.pc_src;
  assign branch_sel = ctrl_q.branch_sel;
  assign jump_sel   = ctrl_q.jump_sel;
  assign mr_sel     = ctrl_q.mr_sel;
  assign mw_sel     = ctrl_q.mw_sel;
  assign mtr_sel    = ctrl_q.mtr_sel;
  assign rw_sel     = ctrl_q.rw_sel;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed self-checking bench for decode_stage. A 32-bit and a 64-bit
//   instance see the same instruction stream; the 64-bit one is checked for
//   its wider immediates.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_src, pc_src, branch_sel, jump_sel, mr_sel, mw_sel, mtr_sel, rw_sel, illegal;
  logic [2:0]  funct3;

  logic        in_ready64, out_valid64;
  logic [63:0] out_pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic [3:0]  alu_op64;
  logic        alu_src64, pc_src64, branch_sel64, jump_sel64, mr_sel64, mw_sel64, mtr_sel64, rw_sel64, illegal64;
  logic [2:0]  funct3_64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign in_pc64 = {32'd0, in_pc};

  decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
    .alu_src(alu_src), .pc_src(pc_src), .branch_sel(branch_sel), .jump_sel(jump_sel),
    .mr_sel(mr_sel), .mw_sel(mw_sel), .mtr_sel(mtr_sel), .rw_sel(rw_sel),
    .funct3(funct3), .illegal(illegal)
  );

  decode_stage #(.XLEN(64), .ALU_OP_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm64), .alu_op(alu_op64),
    .alu_src(alu_src64), .pc_src(pc_src64), .branch_sel(branch_sel64), .jump_sel(jump_sel64),
    .mr_sel(mr_sel64), .mw_sel(mw_sel64), .mtr_sel(mtr_sel64), .rw_sel(rw_sel64),
    .funct3(funct3_64), .illegal(illegal64)
  );

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic ordy, input logic fl, input logic rs);
    in_valid  = v;
    instr     = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset alu_op", alu_op, 4'd0);
    checkOutput("reset rw_sel", rw_sel, 1'b0);
    checkOutput("reset imm", imm, 32'h0);

    // add x3,x1,x2
    applyStimulus(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("idle in_ready", in_ready, 1'b1);
    tick();
    checkOutput("add out_valid", out_valid, 1'b1);
    checkOutput("add rs1", rs1, 5'd1);
    checkOutput("add rs2", rs2, 5'd2);
    checkOutput("add rd", rd, 5'd3);
    checkOutput("add alu_op", alu_op, 4'd0);
    checkOutput("add rw_sel", rw_sel, 1'b1);
    checkOutput("add alu_src", alu_src, 1'b0);
    checkOutput("add out_pc", out_pc, 32'h100);

    // sub x3,x1,x2
    applyStimulus(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("sub alu_op", alu_op, 4'd1);

    // addi x1,x0,-1
    applyStimulus(1'b1, 32'hFFF00093, 32'h108, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("addi imm", imm, 32'hFFFFFFFF);
    checkOutput("addi alu_src", alu_src, 1'b1);
    checkOutput("addi imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

    // srai x1,x1,3
    applyStimulus(1'b1, 32'h4030D093, 32'h10C, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("srai alu_op", alu_op, 4'd7);
    checkOutput("srai imm", imm, 32'd3);

    // beq x0,x0,-8
    applyStimulus(1'b1, 32'hFE000CE3, 32'h110, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("beq branch_sel", branch_sel, 1'b1);
    checkOutput("beq imm", imm, 32'hFFFFFFF8);
    checkOutput("beq alu_op", alu_op, 4'd1);
    checkOutput("beq rw_sel", rw_sel, 1'b0);

    // sw x2,4(x1)
    applyStimulus(1'b1, 32'h0020A223, 32'h114, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("sw mw_sel", mw_sel, 1'b1);
    checkOutput("sw imm", imm, 32'd4);
    checkOutput("sw rw_sel", rw_sel, 1'b0);

    // lui x5,0x12345 : rs1 field is nonzero but must read as x0
    applyStimulus(1'b1, 32'h123452B7, 32'h118, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("lui imm", imm, 32'h12345000);
    checkOutput("lui rs1", rs1, 5'd0);

    // jal x1,16
    applyStimulus(1'b1, 32'h010000EF, 32'h11C, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("jal imm", imm, 32'd16);
    checkOutput("jal jump_sel", jump_sel, 1'b1);
    checkOutput("jal pc_src", pc_src, 1'b1);

    // lw x5,8(x1) then dependent add x6,x5,x5
    applyStimulus(1'b1, 32'h0080A283, 32'h120, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("lw mr_sel", mr_sel, 1'b1);
    checkOutput("lw mtr_sel", mtr_sel, 1'b1);
    checkOutput("lw imm", imm, 32'd8);
    applyStimulus(1'b1, 32'h00528333, 32'h124, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("hazard in_ready", in_ready, 1'b0);
    tick();
    checkOutput("bubble out_valid", out_valid, 1'b0);
    checkOutput("after bubble in_ready", in_ready, 1'b1);
    tick();
    checkOutput("dep add out_valid", out_valid, 1'b1);
    checkOutput("dep add rd", rd, 5'd6);
    checkOutput("dep add rs1", rs1, 5'd5);

    // lw x5,8(x1) then independent add x6,x1,x2 : no bubble
    applyStimulus(1'b1, 32'h0080A283, 32'h128, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00208333, 32'h12C, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("no hazard in_ready", in_ready, 1'b1);
    tick();
    checkOutput("no bubble out_valid", out_valid, 1'b1);
    checkOutput("no bubble rd", rd, 5'd6);
    checkOutput("no bubble mr_sel", mr_sel, 1'b0);

    // Stall for 3 cycles with a pending addi, then flush mid-stall
    applyStimulus(1'b1, 32'hFFF00093, 32'h130, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall in_ready", in_ready, 1'b0);
      tick();
      checkOutput("stall out_valid", out_valid, 1'b1);
      checkOutput("stall rd", rd, 5'd6);
      checkOutput("stall out_pc", out_pc, 32'h12C);
    end
    applyStimulus(1'b1, 32'hFFF00093, 32'h130, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("flush in_ready", in_ready, 1'b0);
    tick();
    checkOutput("flush out_valid", out_valid, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("post flush out_valid", out_valid, 1'b0);

    // Unknown opcode 0x7F
    applyStimulus(1'b1, 32'h0000007F, 32'h140, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("illegal flag", illegal, 1'b1);
    checkOutput("illegal out_valid", out_valid, 1'b1);
    checkOutput("illegal enables",
                {alu_src, pc_src, branch_sel, jump_sel, mr_sel, mw_sel, mtr_sel, rw_sel}, 8'h00);

    // Reset mid-stream beats a concurrent transfer in
    applyStimulus(1'b1, 32'hFFF00093, 32'h144, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("mid reset out_valid", out_valid, 1'b0);
    checkOutput("mid reset imm", imm, 32'h0);

    // slli x1,x1,33 : 6-bit shamt only on RV64
    applyStimulus(1'b1, 32'h02109093, 32'h148, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("slli64 imm", imm64, 64'd33);
    checkOutput("slli64 alu_op", alu_op64, 4'd2);
    checkOutput("slli32 imm", imm, 32'd1);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
